// File: rtl/uart_bus_ctrl_if.sv
// Bus port between the uart_bus_ctrl sequencer (master) and the uart register slave.
// The slave acknowledges combinationally from stb. Read data is valid the cycle after the ack.
interface uart_bus_ctrl_if;
    logic [3:0]  m_adr_o;
    logic [31:0] m_dat_o;
    logic [3:0]  m_sel_o;
    logic        m_we_o;
    logic        m_stb_o;
    logic        m_ack_i;
    logic [31:0] m_dat_i;

    modport master (
        output m_adr_o, m_dat_o, m_sel_o, m_we_o, m_stb_o,
        input  m_ack_i, m_dat_i
    );

    modport slave (
        input  m_adr_o, m_dat_o, m_sel_o, m_we_o, m_stb_o,
        output m_ack_i, m_dat_i
    );
endinterface

// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl: programs the uart divider, then polls status, drains a TX byte FIFO
// and pops RX bytes into a valid/ready stream. Optional counters: UART_BUS_CTRL_STATS_EN.
module uart_bus_ctrl #(
    parameter logic [31:0] DIVIDER   = 32'h000000d7,
    parameter int          TXFIFO_AW = 3
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
`ifdef UART_BUS_CTRL_STATS_EN
    output logic [15:0] tx_count,
    output logic [15:0] rx_count,
`endif
    uart_bus_ctrl_if.master bus
);

    localparam int DEPTH = 1 << TXFIFO_AW;

    typedef enum logic [3:0] {
        ST_INIT, ST_IDLE, ST_RSTAT, ST_SCAP, ST_RRX,
        ST_RCAP, ST_WTX, ST_SETTLE, ST_GAP
    } state_t;

    state_t        state_r, state_s;
    logic          stb_r, stb_s, we_r, we_s;
    logic [3:0]    adr_r, adr_s;
    logic [31:0]   dat_r, dat_s;
    logic          settle_r, settle_s;
    logic          init_done_r;
    logic [7:0]    rx_data_r;
    logic          rx_valid_r;
    logic [7:0]    mem_r [DEPTH];
    logic [TXFIFO_AW:0] wr_ptr_r, rd_ptr_r;
    logic          ack_s, pop_s, push_s, empty_s, full_s;
    logic          unused_dat_s;

    assign ack_s   = stb_r & bus.m_ack_i;
    assign pop_s   = (state_r == ST_WTX) & ack_s;
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[TXFIFO_AW] != rd_ptr_r[TXFIFO_AW]) &&
                     (wr_ptr_r[TXFIFO_AW-1:0] == rd_ptr_r[TXFIFO_AW-1:0]);
    assign tx_ready = init_done_r & ~full_s;
    assign push_s   = tx_valid & tx_ready;
    assign unused_dat_s = ^bus.m_dat_i[31:8];

    assign bus.m_stb_o = stb_r;
    assign bus.m_we_o  = we_r;
    assign bus.m_adr_o = adr_r;
    assign bus.m_dat_o = dat_r;
    assign bus.m_sel_o = 4'hF;
    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;

    // Next-state and next bus-request decode; a request holds stb until its ack.
    always_comb begin
        state_s  = state_r;
        stb_s    = stb_r;
        we_s     = we_r;
        adr_s    = adr_r;
        dat_s    = dat_r;
        settle_s = settle_r;
        case (state_r)
            ST_INIT: begin
                if (ack_s) begin
                    state_s = ST_GAP;
                    stb_s   = 1'b0;
                    we_s    = 1'b0;
                end else begin
                    stb_s = 1'b1;
                    we_s  = 1'b1;
                    adr_s = 4'hC;
                    dat_s = DIVIDER;
                end
            end
            ST_IDLE: begin
                state_s = ST_RSTAT;
                stb_s   = 1'b1;
                we_s    = 1'b0;
                adr_s   = 4'h8;
                dat_s   = 32'h0;
            end
            ST_RSTAT, ST_RRX: begin
                if (ack_s) begin
                    state_s = (state_r == ST_RSTAT) ? ST_SCAP : ST_RCAP;
                    stb_s   = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            // Status is on m_dat_i this cycle; RX wins over TX within one poll.
            ST_SCAP: begin
                if (bus.m_dat_i[1] && !rx_valid_r) begin
                    state_s = ST_RRX;
                    stb_s   = 1'b1;
                    we_s    = 1'b0;
                    adr_s   = 4'h4;
                end else if (!bus.m_dat_i[0] && !empty_s) begin
                    state_s = ST_WTX;
                    stb_s   = 1'b1;
                    we_s    = 1'b1;
                    adr_s   = 4'h0;
                    dat_s   = {24'h0, mem_r[rd_ptr_r[TXFIFO_AW-1:0]]};
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_RCAP: state_s = ST_GAP;
            ST_WTX: begin
                if (ack_s) begin
                    state_s  = ST_SETTLE;
                    stb_s    = 1'b0;
                    we_s     = 1'b0;
                    settle_s = 1'b0;
                end else begin
                    state_s = ST_WTX;
                end
            end
            ST_SETTLE: begin
                if (settle_r) begin
                    state_s  = ST_GAP;
                    settle_s = 1'b0;
                end else begin
                    settle_s = 1'b1;
                end
            end
            ST_GAP: state_s = ST_IDLE;
            default: begin
                state_s = ST_INIT;
                stb_s   = 1'b0;
                we_s    = 1'b0;
            end
        endcase
    end

    // State and bus output registers.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_r     <= ST_INIT;
            stb_r       <= 1'b0;
            we_r        <= 1'b0;
            adr_r       <= 4'h0;
            dat_r       <= 32'h0;
            settle_r    <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            stb_r    <= stb_s;
            we_r     <= we_s;
            adr_r    <= adr_s;
            dat_r    <= dat_s;
            settle_r <= settle_s;
            if ((state_r == ST_INIT) && ack_s) begin
                init_done_r <= 1'b1;
            end
        end
    end

    // RX holding register; capture and consume never coincide.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else if (state_r == ST_RCAP) begin
            rx_data_r  <= bus.m_dat_i[7:0];
            rx_valid_r <= 1'b1;
        end else if (rx_valid_r && rx_ready) begin
            rx_valid_r <= 1'b0;
        end
    end

    // TX FIFO pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{TXFIFO_AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{TXFIFO_AW{1'b0}}, 1'b1};
            end
        end
    end

    // TX FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[TXFIFO_AW-1:0]] <= tx_data;
        end
    end

`ifdef UART_BUS_CTRL_STATS_EN
    logic [15:0] tx_cnt_r, rx_cnt_r;

    // Transfer counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            tx_cnt_r <= 16'h0000;
            rx_cnt_r <= 16'h0000;
        end else begin
            if (pop_s) begin
                tx_cnt_r <= tx_cnt_r + 16'h0001;
            end
            if (state_r == ST_RCAP) begin
                rx_cnt_r <= rx_cnt_r + 16'h0001;
            end
        end
    end

    assign tx_count = tx_cnt_r;
    assign rx_count = rx_cnt_r;
`endif

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Scoreboard bench for uart_bus_ctrl: a uart register stub answers the bus, expected
// bus writes and RX bytes are queued by the stimulus and checked by a monitor.
module tb_uart_bus_ctrl;

    logic       clk;
    logic       rst_i;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int tx_write_cnt = 0;
    int rx_read_cnt = 0;
    int accept_txcnt = 0;
    int low_cnt = 0;
    bit after_write = 1'b0;

    logic [35:0] exp_wr_q[$];
    logic [7:0]  exp_rx_q[$];
    logic [7:0]  stub_rx_q[$];

    uart_bus_ctrl_if bus_if();

    uart_bus_ctrl dut (
        .clk      (clk),
        .rst_i    (rst_i),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .bus      (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus_if.m_ack_i = bus_if.m_stb_o;

    // uart register stub: status reflects busy and its RX queue; RX read pops it
    always @(posedge clk) begin
        if (rst_i) begin
            bus_if.m_dat_i <= 32'h0;
        end else if (bus_if.m_stb_o && !bus_if.m_we_o) begin
            if (bus_if.m_adr_o == 4'h8) begin
                bus_if.m_dat_i <= {30'h0, (stub_rx_q.size() != 0), busy};
            end else if (bus_if.m_adr_o == 4'h4 && stub_rx_q.size() != 0) begin
                bus_if.m_dat_i <= {24'h0, stub_rx_q.pop_front()};
            end else begin
                bus_if.m_dat_i <= 32'h0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: bus writes, TX inter-write gap, RX stream consumption
    always @(negedge clk) begin
        if (rst_i) begin
            after_write = 1'b0;
            low_cnt = 0;
        end else begin
            if (bus_if.m_stb_o) begin
                if (after_write) begin
                    tests++;
                    if (low_cnt < 3) begin
                        fails++;
                        $display("FAIL tx_gap: stb low for %0d cycles, required >= 3", low_cnt);
                    end
                    after_write = 1'b0;
                end
                low_cnt = 0;
                if (bus_if.m_ack_i && bus_if.m_we_o) begin
                    check("wr_sel", bus_if.m_sel_o, 4'hF);
                    if (exp_wr_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: adr %h dat %h, required no write",
                                 bus_if.m_adr_o, bus_if.m_dat_o);
                    end else begin
                        check("wr_adr_dat", {bus_if.m_adr_o, bus_if.m_dat_o}, exp_wr_q.pop_front());
                    end
                    if (bus_if.m_adr_o == 4'h0) begin
                        tx_write_cnt++;
                        after_write = 1'b1;
                    end
                end else if (bus_if.m_ack_i && bus_if.m_adr_o == 4'h4) begin
                    rx_read_cnt++;
                end
            end else begin
                low_cnt++;
            end
            if (rx_valid && rx_ready) begin
                if (exp_rx_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rx: byte %h, required none", rx_data);
                end else begin
                    check("rx_byte", rx_data, exp_rx_q.pop_front());
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_data = b;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            accept_txcnt = tx_write_cnt;
            exp_wr_q.push_back({4'h0, 24'h0, b});
            @(posedge clk);
            #1;
        end else begin
            tests++;
            fails++;
            $display("FAIL push_timeout: byte %h not accepted in 500 cycles, required acceptance", b);
        end
        tx_valid = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (exp_wr_q.size() == 0 && exp_rx_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d writes and %0d rx bytes pending, required 0",
                     exp_wr_q.size(), exp_rx_q.size());
        end
    endtask

    initial begin
        int rd0;
        int cnt1;
        bit found;
        rst_i = 1'b1;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        rx_ready = 1'b0;
        busy = 1'b0;
        exp_wr_q.push_back({4'hC, 32'h000000d7});

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stb", bus_if.m_stb_o, 1'b0);
        check("rst_we", bus_if.m_we_o, 1'b0);
        check("rst_adr", bus_if.m_adr_o, 4'h0);
        check("rst_dat", bus_if.m_dat_o, 32'h0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_tx_ready", tx_ready, 1'b0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // divider write comes first; tx_ready only after it
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus_if.m_stb_o) begin
                found = 1'b1;
                break;
            end
        end
        check("init_stb_seen", found, 1'b1);
        check("init_adr", bus_if.m_adr_o, 4'hC);
        check("init_tx_ready_low", tx_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("init_tx_ready_high", tx_ready, 1'b1);

        // single byte, idle uart
        push(8'h41);
        wait_empty(500);

        // busy uart holds TX writes, then ordered drain
        @(posedge clk);
        #1;
        busy = 1'b1;
        cnt1 = tx_write_cnt;
        push(8'h41);
        push(8'h42);
        push(8'h43);
        repeat (100) @(negedge clk);
        check("busy_no_write", tx_write_cnt, cnt1);
        @(posedge clk);
        #1;
        busy = 1'b0;
        wait_empty(1000);

        // RX byte held while client stalls; no further RX reads
        rd0 = rx_read_cnt;
        @(posedge clk);
        #1;
        stub_rx_q.push_back(8'h5A);
        exp_rx_q.push_back(8'h5A);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rx_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("rx_valid_seen", found, 1'b1);
        check("rx_data_5a", rx_data, 8'h5A);
        stub_rx_q.push_back(8'hA5);
        exp_rx_q.push_back(8'hA5);
        repeat (50) @(negedge clk);
        check("rx_hold_reads", rx_read_cnt, rd0 + 1);
        check("rx_hold_valid", rx_valid, 1'b1);
        check("rx_hold_data", rx_data, 8'h5A);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        wait_empty(1000);
        @(posedge clk);
        #1;
        rx_ready = 1'b0;

        // FIFO full with busy uart; ninth byte waits for first TX ack
        @(posedge clk);
        #1;
        busy = 1'b1;
        cnt1 = tx_write_cnt;
        for (int i = 0; i < 8; i++) begin
            push(8'(8'hB0 + i));
        end
        @(negedge clk);
        check("full_tx_ready", tx_ready, 1'b0);
        fork
            begin
                push(8'hC8);
                check("ninth_after_first_ack", accept_txcnt, cnt1 + 1);
            end
            begin
                repeat (30) @(negedge clk);
                check("full_no_write", tx_write_cnt, cnt1);
                @(posedge clk);
                #1;
                busy = 1'b0;
            end
        join
        wait_empty(2000);

        // reset during RX read bus cycle
        @(posedge clk);
        #1;
        stub_rx_q.push_back(8'h77);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus_if.m_stb_o && !bus_if.m_we_o && bus_if.m_adr_o == 4'h4) begin
                found = 1'b1;
                break;
            end
        end
        check("rrx_seen", found, 1'b1);
        rst_i = 1'b1;
        @(negedge clk);
        check("abort_stb", bus_if.m_stb_o, 1'b0);
        check("abort_rx_valid", rx_valid, 1'b0);
        check("abort_tx_ready", tx_ready, 1'b0);
        stub_rx_q.delete();
        exp_wr_q.push_back({4'hC, 32'h000000d7});
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        wait_empty(200);

        repeat (20) @(negedge clk);
        check("final_wr_q_empty", exp_wr_q.size(), 0);
        check("final_rx_q_empty", exp_rx_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_bus_ctrl.md
Name: uart_bus_ctrl

Overview:
- Bus-master sequencer that owns the uart slave port.
- After reset it programs the baud divider.
- It then polls status, drains a local TX byte FIFO into the TX data register, and pops received bytes into a valid/ready stream.
- Sits between a byte-stream client (console/DMA logic) and the uart, so the CPU never polls uart registers directly.

Parameters:
- DIVIDER, 32'h000000d7: value written to uart divider register (reg 3) after reset.
- TXFIFO_AW, 3: log2 of TX FIFO depth (default 8 entries).

Ports:
- clk  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- tx_data  in  8  byte to transmit
- tx_valid  in  1  client offers tx_data
- tx_ready  out  1  FIFO not full; byte accepted when tx_valid&tx_ready at posedge
- rx_data  out  8  received byte
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_ready  in  1  client consumes rx_data when rx_valid&rx_ready at posedge
- m_adr_o  out  4  uart address; [3:2] selects reg: 0 TXDATA, 1 RXDATA, 2 STATUS, 3 DIVIDER
- m_dat_o  out  32  write data
- m_sel_o  out  4  byte selects, always 4'b1111
- m_we_o  out  1  write strobe qualifier
- m_stb_o  out  1  bus cycle request
- m_ack_i  in  1  slave acknowledge (combinational from stb)
- m_dat_i  in  32  read data, valid the cycle after the ack cycle

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst_i).
- Reset:
  - m_stb_o=0, m_we_o=0, m_adr_o=0, m_dat_o=0.
  - rx_valid=0, rx_data=0.
  - FIFO emptied; tx_ready=0 until INIT completes.
  - State=INIT.
  - Reset mid-transaction aborts immediately; stb drops the next cycle.
- Bus rules:
  - Every access asserts stb until ack, then drops stb for at least one cycle. The uart pops its RX FIFO on the first stb-low cycle after an RX read.
  - Reads capture m_dat_i in the cycle after ack.
- STATUS bits: [0]=tx busy, [1]=rx byte available.
- FSM:
  - INIT: write DIVIDER to adr 4'hC -> GAP.
  - IDLE: always -> RSTAT. Issue read of adr 4'h8.
  - RSTAT: on ack -> SCAP.
  - SCAP: latch status.
    - If bit1=1 and rx_valid=0 -> RRX. Read adr 4'h4.
    - Else if bit0=0 and FIFO non-empty -> WTX. Write {24'h0, fifo head} to adr 4'h0.
    - Else -> GAP.
  - RRX: on ack -> RCAP.
  - RCAP: rx_data<=m_dat_i[7:0], rx_valid<=1 -> GAP.
  - WTX: on ack, pop FIFO -> SETTLE.
  - SETTLE: 2 idle cycles, so the status busy bit is visible -> GAP.
  - GAP: 1 cycle, stb low -> IDLE.
- Priority:
  - RX is serviced before TX in the same poll.
  - No RX pop while rx_valid=1; the uart's own FIFO buffers meanwhile.
- rx_valid clears on rx_valid&rx_ready. A new RCAP is impossible in the same cycle because of the rx_valid check.
- TX FIFO:
  - Circular, pointers TXFIFO_AW+1 bits wide; full/empty distinguished by MSB.
  - Push when tx_valid&tx_ready.
  - Push and pop in the same cycle are both honoured; count unchanged.
  - Push when full is ignored (tx_ready=0).
- Ordering: bytes are written to the uart strictly in acceptance order; no drops, no duplicates.

Optional Feature:
- Macro: UART_BUS_CTRL_STATS_EN.
- Defined:
  - Adds outputs tx_count[15:0] and rx_count[15:0], reset 0.
  - tx_count increments on each WTX ack; rx_count increments on each RCAP.
  - Both wrap at 16'hFFFF->0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset release -> first bus cycle is a write of 32'h000000d7 to adr 4'hC, m_sel_o=4'hF; tx_ready rises only after it.
- Push 8'h41, status stub returns 32'h0 -> write of 32'h00000041 to adr 4'h0, followed by stb low for 3 or more cycles.
- Push 8'h41, 8'h42, 8'h43 with busy=1 held for 100 cycles -> no TXDATA write until busy=0, then writes in order 41, 42, 43.
- Status returns 32'h2 with RX reg 8'h5A -> rx_valid=1 with rx_data=8'h5A; while rx_ready=0 no further RXDATA reads despite status 32'h2.
- Push 9 bytes with busy=1 and TXFIFO_AW=3 -> tx_ready=0 after 8; ninth accepted only after the first WTX ack.
- Assert rst_i during the RRX stb cycle -> stb=0 the next cycle, rx_valid=0, FSM restarts with the divider write.
